// File: rtl/bcd_counter.sv
// Multi-digit synchronous BCD up/down counter with validated load, enable and terminal count.
// Define BCD_COUNTER_SATURATE_EN to hold at 99..9 / 00..0 instead of wrapping around.
module bcd_counter #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tc,
   output logic                  load_err
);

   // nine_chain[i] / zero_chain[i]: digits 0..i-1 are all 9 / all 0
   logic [DIGITS:0]   nine_chain;
   logic [DIGITS:0]   zero_chain;
   logic [DIGITS-1:0] digit_ok;
   logic              load_ok;
   logic              at_limit;
   logic              hold_at_limit;
   logic              load_err_reg;

   assign nine_chain[0] = 1'b1;
   assign zero_chain[0] = 1'b1;
   assign load_ok       = &digit_ok;
   assign at_limit      = up ? nine_chain[DIGITS] : zero_chain[DIGITS];

`ifdef BCD_COUNTER_SATURATE_EN
   assign hold_at_limit = at_limit;
`else
   assign hold_at_limit = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
         logic [3:0] digit_reg;
         logic [3:0] digit_next;
         logic [3:0] load_digit;

         assign load_digit         = load_val[4*gi +: 4];
         assign digit_ok[gi]       = (load_digit <= 4'd9);
         assign nine_chain[gi + 1] = nine_chain[gi] & (digit_reg == 4'd9);
         assign zero_chain[gi + 1] = zero_chain[gi] & (digit_reg == 4'd0);

         always_comb begin
            digit_next = digit_reg;
            if (up) begin
               if (nine_chain[gi])
                  digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
            end else begin
               if (zero_chain[gi])
                  digit_next = (digit_reg == 4'd0) ? 4'd9 : digit_reg - 4'd1;
            end
         end

         // A rejected load still blocks the count step on that edge
         always_ff @(posedge clk) begin
            if (rst) begin
               digit_reg <= 4'd0;
            end else if (load) begin
               if (load_ok)
                  digit_reg <= load_digit;
            end else if (en && !hold_at_limit) begin
               digit_reg <= digit_next;
            end
         end

         assign bcd[4*gi +: 4] = digit_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         load_err_reg <= 1'b0;
      else
         load_err_reg <= load & ~load_ok;
   end

   assign load_err = load_err_reg;
   assign tc       = en & ~load & ~rst & at_limit;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed plus random stimulus for bcd_counter; an integer model feeds a scoreboard queue.
module tb_bcd_counter;
   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = 99;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] bcd;
   logic         tc;
   logic         load_err;

   int checks   = 0;
   int failures = 0;
   int m_val    = 0;
   int tc_hits  = 0;
   logic [W:0] sb_q[$];

   bcd_counter #(.DIGITS(DIGITS)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .bcd(bcd), .tc(tc), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit bcd_valid(input logic [W-1:0] v);
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      int m = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r += int'(v[4*i +: 4]) * m;
         m *= 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r = '0;
      int t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // One clock: drive, check tc, push model result, wait edge, pop and compare
   task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                      input logic [W-1:0] lv);
      logic       exp_tc;
      logic       exp_err;
      logic [W:0] got;
      rst = r; en = e; up = u; load = l; load_val = lv;
      #1;
      exp_tc = !r && e && !l && (u ? (m_val == MAXV) : (m_val == 0));
      check("tc", 32'(tc), 32'(exp_tc));
      if (tc === 1'b1) tc_hits++;
      exp_err = 1'b0;
      if (r) begin
         m_val = 0;
      end else if (l) begin
         if (bcd_valid(lv)) m_val = bcd2int(lv);
         else exp_err = 1'b1;
      end else if (e) begin
         if (u) begin
`ifdef BCD_COUNTER_SATURATE_EN
            if (m_val != MAXV) m_val = m_val + 1;
`else
            m_val = (m_val == MAXV) ? 0 : m_val + 1;
`endif
         end else begin
`ifdef BCD_COUNTER_SATURATE_EN
            if (m_val != 0) m_val = m_val - 1;
`else
            m_val = (m_val == 0) ? MAXV : m_val - 1;
`endif
         end
      end
      sb_q.push_back({exp_err, int2bcd(m_val)});
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check("bcd", 32'(bcd), 32'(got[W-1:0]));
      check("load_err", 32'(load_err), 32'(got[W]));
      $display("rst=%b en=%b up=%b load=%b load_val=%h -> bcd=%h load_err=%b tc=%b",
               r, e, u, l, lv, bcd, load_err, exp_tc);
   endtask

   initial begin
      // Reset with every other input active
      cyc(1, 1, 1, 1, 8'h55);
      cyc(1, 1, 1, 1, 8'h55);
      check("reset_bcd", 32'(bcd), 32'h00);

      // Up sweep over the full range
      tc_hits = 0;
      for (int i = 0; i < 100; i++) cyc(0, 1, 1, 0, 8'h00);
      check("sweep_tc_count", 32'(tc_hits), 32'd1);
`ifdef BCD_COUNTER_SATURATE_EN
      check("sweep_end", 32'(bcd), 32'h99);
`else
      check("sweep_end", 32'(bcd), 32'h00);
`endif

      // Down wrap
      cyc(0, 0, 1, 1, 8'h01);
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'h00);
`ifdef BCD_COUNTER_SATURATE_EN
      check("down_end", 32'(bcd), 32'h00);
`else
      check("down_end", 32'(bcd), 32'h98);
`endif

      // Load validation
      cyc(0, 0, 1, 1, 8'h47);
      check("load_47", 32'(bcd), 32'h47);
      cyc(0, 0, 1, 1, 8'h4A);
      check("bad_load_hold", 32'(bcd), 32'h47);
      check("bad_load_err", 32'(load_err), 32'd1);
      cyc(0, 0, 1, 0, 8'h00);
      check("err_clears", 32'(load_err), 32'd0);

      // Priority: load over en, reset over load
      cyc(0, 0, 1, 1, 8'h12);
      cyc(0, 1, 1, 1, 8'h30);
      check("load_over_en", 32'(bcd), 32'h30);
      cyc(1, 0, 1, 1, 8'h30);
      check("rst_over_load", 32'(bcd), 32'h00);

      // Hold and mid-run reset
      cyc(0, 0, 1, 1, 8'h37);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'h00);
      check("hold_37", 32'(bcd), 32'h37);
      cyc(1, 1, 1, 0, 8'h00);
      cyc(0, 1, 1, 0, 8'h00);
      check("resume_01", 32'(bcd), 32'h01);

      // Digit borrow/carry boundaries
      cyc(0, 0, 1, 1, 8'h10);
      cyc(0, 1, 0, 0, 8'h00);
      check("borrow_09", 32'(bcd), 32'h09);
      cyc(0, 1, 1, 0, 8'h00);
      check("carry_10", 32'(bcd), 32'h10);

      // Random mix, reset kept rare
      for (int i = 0; i < 200; i++) begin
         logic [W-1:0] lv;
         lv = W'($urandom_range(0, 255));
         cyc(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0), lv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
